// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the decode-side fetch control:
// opcodes, branch funct3 values and the canonical NOP.
package riscv_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] NOP_ENC = 32'h0000_0013;

   // A register match that can cause a hazard; x0 is never a dependency.
   function automatic logic reg_hit(input logic [4:0] r, input logic uses_rs1,
                                    input logic uses_rs2, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
      reg_hit = (r != 5'd0) && ((uses_rs1 && (r == rs1)) || (uses_rs2 && (r == rs2)));
   endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational control-flow resolution for the instruction in ID:
// operand compare, immediate generation, target and taken.
module branch_unit
   import riscv_pkg::*;
(
   input  logic [31:0] i_insn,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   output logic        o_is_cf,
   output logic        o_taken,
   output logic [31:0] o_target
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_j;
   logic [31:0] w_imm_i;
   logic        w_eq;
   logic        w_lt_s;
   logic        w_lt_u;
   logic        w_br_taken;

   assign w_opcode = i_insn[6:0];
   assign w_funct3 = i_insn[14:12];

   assign w_imm_b = {{20{i_insn[31]}}, i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
   assign w_imm_j = {{12{i_insn[31]}}, i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
   assign w_imm_i = {{20{i_insn[31]}}, i_insn[31:20]};

   assign w_eq   = (i_rs1_data == i_rs2_data);
   assign w_lt_s = ($signed(i_rs1_data) < $signed(i_rs2_data));
   assign w_lt_u = (i_rs1_data < i_rs2_data);

   always_comb begin
      w_br_taken = 1'b0;
      case (w_funct3)
         F3_BEQ:  w_br_taken = w_eq;
         F3_BNE:  w_br_taken = !w_eq;
         F3_BLT:  w_br_taken = w_lt_s;
         F3_BGE:  w_br_taken = !w_lt_s;
         F3_BLTU: w_br_taken = w_lt_u;
         F3_BGEU: w_br_taken = !w_lt_u;
         default: w_br_taken = 1'b0;
      endcase
   end

   always_comb begin
      o_is_cf  = 1'b0;
      o_taken  = 1'b0;
      o_target = 32'd0;
      case (w_opcode)
         OP_BRANCH: begin
            o_is_cf  = 1'b1;
            o_taken  = w_br_taken;
            o_target = i_pc + w_imm_b;
         end
         OP_JAL: begin
            o_is_cf  = 1'b1;
            o_taken  = 1'b1;
            o_target = i_pc + w_imm_j;
         end
         OP_JALR: begin
            o_is_cf  = 1'b1;
            o_taken  = 1'b1;
            o_target = (i_rs1_data + w_imm_i) & ~32'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_fetch_ctrl.sv
// IF/ID pipeline register with hazard detection, redirect generation and
// saturating stall/flush event counters.
module id_fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] NOP_INSN = NOP_ENC,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      PC_IF,
   input  logic [31:0]      INSTRUCTION_IF,
   input  logic             ID_EX_MemRead,
   input  logic             ID_EX_RegWrite,
   input  logic [4:0]       ID_EX_rd,
   input  logic             EX_MEM_MemRead,
   input  logic [4:0]       EX_MEM_rd,
   input  logic [31:0]      RS1_DATA,
   input  logic [31:0]      RS2_DATA,
   output logic             PC_write,
   output logic             PCSrc,
   output logic [31:0]      PC_Branch,
   output logic [31:0]      PC_ID,
   output logic [31:0]      INSTRUCTION_ID,
   output logic             VALID_ID,
   output logic             BUBBLE_ID,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   logic [31:0]      r_pc_id;
   logic [31:0]      r_insn_id;
   logic             r_valid_id;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [6:0]  w_opcode;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic        w_uses_rs1;
   logic        w_uses_rs2;
   logic        w_cf_needs_ops;
   logic        w_hit_ex;
   logic        w_hit_mem;
   logic        w_stall;
   logic        w_is_cf;
   logic        w_taken;
   logic [31:0] w_target;
   logic        w_redirect;

   assign w_opcode = r_insn_id[6:0];
   assign w_rs1    = r_insn_id[19:15];
   assign w_rs2    = r_insn_id[24:20];

   assign w_uses_rs1 = (w_opcode != OP_LUI) && (w_opcode != OP_AUIPC) && (w_opcode != OP_JAL);
   assign w_uses_rs2 = (w_opcode == OP_R) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
   assign w_cf_needs_ops = (w_opcode == OP_BRANCH) || (w_opcode == OP_JALR);

   assign w_hit_ex  = reg_hit(ID_EX_rd, w_uses_rs1, w_uses_rs2, w_rs1, w_rs2);
   assign w_hit_mem = reg_hit(EX_MEM_rd, w_uses_rs1, w_uses_rs2, w_rs1, w_rs2);

   // Branches and JALR resolve in ID, so they also wait on any EX writer and on a load in MEM.
   assign w_stall = r_valid_id &&
                    ((ID_EX_MemRead && w_hit_ex) ||
                     (w_cf_needs_ops && ((ID_EX_RegWrite && w_hit_ex) ||
                                         (EX_MEM_MemRead && w_hit_mem))));

   branch_unit u_branch (
      .i_insn     (r_insn_id),
      .i_pc       (r_pc_id),
      .i_rs1_data (RS1_DATA),
      .i_rs2_data (RS2_DATA),
      .o_is_cf    (w_is_cf),
      .o_taken    (w_taken),
      .o_target   (w_target)
   );

   assign w_redirect = r_valid_id && w_taken && !w_stall;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc_id     <= 32'd0;
         r_insn_id   <= NOP_INSN;
         r_valid_id  <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (w_stall) begin
         if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + 1'b1;
      end else if (w_redirect) begin
         r_pc_id    <= PC_IF;
         r_insn_id  <= NOP_INSN;
         r_valid_id <= 1'b0;
         if (r_flush_cnt != {CNT_W{1'b1}}) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else begin
         r_pc_id    <= PC_IF;
         r_insn_id  <= INSTRUCTION_IF;
         r_valid_id <= 1'b1;
      end
   end

   assign PC_write       = !w_stall;
   assign BUBBLE_ID      = w_stall;
   assign PCSrc          = w_redirect;
   assign PC_Branch      = w_is_cf ? w_target : 32'd0;
   assign PC_ID          = r_pc_id;
   assign INSTRUCTION_ID = r_insn_id;
   assign VALID_ID       = r_valid_id;
   assign STALL_CNT      = r_stall_cnt;
   assign FLUSH_CNT      = r_flush_cnt;

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// Directed bench for id_fetch_ctrl: reset, pipelining, load-use and branch
// hazards, redirects, reset during stall and counter saturation.
module tb_id_fetch_ctrl;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] ADDI  = 32'h0010_0093; // addi x1,x0,1
   localparam logic [31:0] ADD   = 32'h0020_81B3; // add x3,x1,x2
   localparam logic [31:0] BEQ   = 32'h0020_8863; // beq x1,x2,+16
   localparam logic [31:0] BNE   = 32'h0020_9863; // bne x1,x2,+16
   localparam logic [31:0] BLT   = 32'h0020_C863; // blt x1,x2,+16
   localparam logic [31:0] BLTU  = 32'h0020_E863; // bltu x1,x2,+16
   localparam logic [31:0] JALR  = 32'h0000_8067; // jalr x0,0(x1)
   localparam logic [31:0] JAL   = 32'h0080_006F; // jal x0,+8

   logic        clk;
   logic        reset;
   logic [31:0] PC_IF;
   logic [31:0] INSTRUCTION_IF;
   logic        ID_EX_MemRead;
   logic        ID_EX_RegWrite;
   logic [4:0]  ID_EX_rd;
   logic        EX_MEM_MemRead;
   logic [4:0]  EX_MEM_rd;
   logic [31:0] RS1_DATA;
   logic [31:0] RS2_DATA;
   logic        PC_write;
   logic        PCSrc;
   logic [31:0] PC_Branch;
   logic [31:0] PC_ID;
   logic [31:0] INSTRUCTION_ID;
   logic        VALID_ID;
   logic        BUBBLE_ID;
   logic [15:0] STALL_CNT;
   logic [15:0] FLUSH_CNT;

   int checks;
   int failures;

   id_fetch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .PC_IF          (PC_IF),
      .INSTRUCTION_IF (INSTRUCTION_IF),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .ID_EX_RegWrite (ID_EX_RegWrite),
      .ID_EX_rd       (ID_EX_rd),
      .EX_MEM_MemRead (EX_MEM_MemRead),
      .EX_MEM_rd      (EX_MEM_rd),
      .RS1_DATA       (RS1_DATA),
      .RS2_DATA       (RS2_DATA),
      .PC_write       (PC_write),
      .PCSrc          (PCSrc),
      .PC_Branch      (PC_Branch),
      .PC_ID          (PC_ID),
      .INSTRUCTION_ID (INSTRUCTION_ID),
      .VALID_ID       (VALID_ID),
      .BUBBLE_ID      (BUBBLE_ID),
      .STALL_CNT      (STALL_CNT),
      .FLUSH_CNT      (FLUSH_CNT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] insn);
      PC_IF          = pc;
      INSTRUCTION_IF = insn;
   endtask

   task automatic clear_hazards();
      ID_EX_MemRead  = 1'b0;
      ID_EX_RegWrite = 1'b0;
      ID_EX_rd       = 5'd0;
      EX_MEM_MemRead = 1'b0;
      EX_MEM_rd      = 5'd0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      RS1_DATA = 32'd0;
      RS2_DATA = 32'd0;
      clear_hazards();
      fetch(32'hDEAD_BEEC, ADD);

      // Reset for two edges
      tick();
      tick();
      chk("rst_pc_id", PC_ID, 32'd0);
      chk("rst_insn", INSTRUCTION_ID, NOP);
      chk("rst_valid", {31'd0, VALID_ID}, 32'd0);
      chk("rst_stall_cnt", {16'd0, STALL_CNT}, 32'd0);
      chk("rst_flush_cnt", {16'd0, FLUSH_CNT}, 32'd0);
      chk("rst_pc_write", {31'd0, PC_write}, 32'd1);
      chk("rst_pcsrc", {31'd0, PCSrc}, 32'd0);
      chk("rst_bubble", {31'd0, BUBBLE_ID}, 32'd0);

      // Straight-line fetch
      reset = 1'b1;
      fetch(32'h0, ADDI);
      tick();
      chk("seq0_pc", PC_ID, 32'h0);
      chk("seq0_valid", {31'd0, VALID_ID}, 32'd1);
      fetch(32'h4, ADDI);
      tick();
      chk("seq4_pc", PC_ID, 32'h4);
      fetch(32'h8, ADDI);
      tick();
      chk("seq8_pc", PC_ID, 32'h8);
      chk("seq8_insn", INSTRUCTION_ID, ADDI);
      chk("seq_pc_write", {31'd0, PC_write}, 32'd1);
      chk("seq_stall_cnt", {16'd0, STALL_CNT}, 32'd0);

      // Load-use on x1
      fetch(32'hC, ADD);
      tick();
      ID_EX_MemRead = 1'b1;
      ID_EX_rd      = 5'd1;
      fetch(32'h10, ADDI);
      settle();
      chk("lu_pc_write", {31'd0, PC_write}, 32'd0);
      chk("lu_bubble", {31'd0, BUBBLE_ID}, 32'd1);
      tick();
      chk("lu_hold_pc", PC_ID, 32'hC);
      chk("lu_hold_insn", INSTRUCTION_ID, ADD);
      chk("lu_stall_cnt", {16'd0, STALL_CNT}, 32'd1);
      clear_hazards();
      settle();
      chk("lu_release", {31'd0, PC_write}, 32'd1);
      tick();
      chk("lu_next_pc", PC_ID, 32'h10);

      // Load into x0 never stalls
      fetch(32'h14, ADD);
      tick();
      ID_EX_MemRead = 1'b1;
      ID_EX_rd      = 5'd0;
      settle();
      chk("x0_pc_write", {31'd0, PC_write}, 32'd1);
      chk("x0_bubble", {31'd0, BUBBLE_ID}, 32'd0);
      clear_hazards();

      // BEQ taken
      fetch(32'h100, BEQ);
      tick();
      RS1_DATA = 32'd5;
      RS2_DATA = 32'd5;
      fetch(32'h104, ADDI);
      settle();
      chk("beq_pcsrc", {31'd0, PCSrc}, 32'd1);
      chk("beq_target", PC_Branch, 32'h110);
      tick();
      chk("beq_flush_insn", INSTRUCTION_ID, NOP);
      chk("beq_flush_valid", {31'd0, VALID_ID}, 32'd0);
      chk("beq_flush_cnt", {16'd0, FLUSH_CNT}, 32'd1);
      chk("beq_flush_pcsrc", {31'd0, PCSrc}, 32'd0);

      // BEQ not taken
      fetch(32'h200, BEQ);
      tick();
      RS2_DATA = 32'd6;
      settle();
      chk("beqn_pcsrc", {31'd0, PCSrc}, 32'd0);
      chk("beqn_target", PC_Branch, 32'h210);
      fetch(32'h204, ADDI);
      tick();
      chk("beqn_valid", {31'd0, VALID_ID}, 32'd1);
      chk("beqn_flush_cnt", {16'd0, FLUSH_CNT}, 32'd1);

      // Signed vs unsigned compare
      fetch(32'h300, BLT);
      tick();
      RS1_DATA = 32'hFFFF_FFFF;
      RS2_DATA = 32'd1;
      settle();
      chk("blt_pcsrc", {31'd0, PCSrc}, 32'd1);
      chk("blt_target", PC_Branch, 32'h310);
      fetch(32'h310, BLTU);
      tick();
      chk("blt_flush_cnt", {16'd0, FLUSH_CNT}, 32'd2);
      tick();
      chk("bltu_loaded", INSTRUCTION_ID, BLTU);
      chk("bltu_pcsrc", {31'd0, PCSrc}, 32'd0);

      // JALR clears bit 0
      fetch(32'h314, JALR);
      tick();
      RS1_DATA = 32'h203;
      settle();
      chk("jalr_pcsrc", {31'd0, PCSrc}, 32'd1);
      chk("jalr_target", PC_Branch, 32'h202);
      fetch(32'h202, ADDI);
      tick();
      chk("jalr_flush_cnt", {16'd0, FLUSH_CNT}, 32'd3);
      tick();
      chk("jalr_land_pc", PC_ID, 32'h202);
      chk("addi_pc_branch", PC_Branch, 32'd0);

      // BNE on a load result: EX then MEM, two stall cycles
      fetch(32'h400, BNE);
      tick();
      RS1_DATA       = 32'd3;
      RS2_DATA       = 32'd7;
      ID_EX_MemRead  = 1'b1;
      ID_EX_RegWrite = 1'b1;
      ID_EX_rd       = 5'd1;
      fetch(32'h404, ADDI);
      settle();
      chk("bne_st1_pc_write", {31'd0, PC_write}, 32'd0);
      chk("bne_st1_pcsrc", {31'd0, PCSrc}, 32'd0);
      tick();
      chk("bne_st1_cnt", {16'd0, STALL_CNT}, 32'd2);
      clear_hazards();
      EX_MEM_MemRead = 1'b1;
      EX_MEM_rd      = 5'd1;
      settle();
      chk("bne_st2_pc_write", {31'd0, PC_write}, 32'd0);
      chk("bne_st2_pcsrc", {31'd0, PCSrc}, 32'd0);
      tick();
      chk("bne_st2_cnt", {16'd0, STALL_CNT}, 32'd3);
      chk("bne_hold_pc", PC_ID, 32'h400);
      clear_hazards();
      settle();
      chk("bne_pcsrc", {31'd0, PCSrc}, 32'd1);
      chk("bne_target", PC_Branch, 32'h410);
      tick();
      chk("bne_flush_cnt", {16'd0, FLUSH_CNT}, 32'd4);

      // JAL
      fetch(32'h500, JAL);
      tick();
      settle();
      chk("jal_pcsrc", {31'd0, PCSrc}, 32'd1);
      chk("jal_target", PC_Branch, 32'h508);
      fetch(32'h504, ADDI);
      tick();
      chk("jal_flush_cnt", {16'd0, FLUSH_CNT}, 32'd5);

      // Reset in the middle of a stall
      fetch(32'h600, ADD);
      tick();
      ID_EX_MemRead = 1'b1;
      ID_EX_rd      = 5'd1;
      settle();
      chk("rs_pre_stall", {31'd0, PC_write}, 32'd0);
      reset = 1'b0;
      tick();
      chk("rs_insn", INSTRUCTION_ID, NOP);
      chk("rs_valid", {31'd0, VALID_ID}, 32'd0);
      chk("rs_stall_cnt", {16'd0, STALL_CNT}, 32'd0);
      chk("rs_flush_cnt", {16'd0, FLUSH_CNT}, 32'd0);
      chk("rs_pc_write", {31'd0, PC_write}, 32'd1);

      // Stall counter saturation
      reset = 1'b1;
      clear_hazards();
      fetch(32'h700, ADD);
      tick();
      ID_EX_MemRead = 1'b1;
      ID_EX_rd      = 5'd2;
      for (int i = 0; i < 65535; i++) tick();
      chk("sat_at_max", {16'd0, STALL_CNT}, 32'h0000_FFFF);
      for (int i = 0; i < 4; i++) tick();
      chk("sat_hold", {16'd0, STALL_CNT}, 32'h0000_FFFF);
      chk("sat_insn_held", INSTRUCTION_ID, ADD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
